// File: rtl/src_sw_pkg.sv
// Shared constants and state type for the audio source-switch controller.
// Contents: source count, select/gain widths, fade step, settle length,
// and the switch-sequence state enum.
package src_sw_pkg;

  localparam int NUM_SRC  = 5;
  localparam int SEL_W    = 3;
  localparam int GAIN_W   = 8;
  localparam int GAIN_MAX = 2**GAIN_W - 1;  // unity gain
  localparam int STEP     = 8;              // gain change per sample_tick
  localparam int SETTLE   = 4;              // sample_ticks held at gain 0

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWITCH,
    FADE_IN
  } sw_state_t;

endpackage

// File: rtl/src_switch_ctrl_gain_ramp.sv
// gain_ramp: saturating up/down gain stepper.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (gain resets to GAIN_MAX)
//   tick        apply one step this cycle
//   dir         1 = ramp up toward GAIN_MAX, 0 = ramp down toward 0
//   gain        registered gain word
//   at_zero     the gain register holds 0 after this clock edge
//   at_max      the gain register holds GAIN_MAX after this clock edge
// The flags look at the value being loaded so the controller can change
// state in the same cycle the gain reaches a rail.
module gain_ramp
  import src_sw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              dir,
  output logic [GAIN_W-1:0] gain,
  output logic              at_zero,
  output logic              at_max
);

  localparam logic [GAIN_W:0] STEP_W = (GAIN_W+1)'(STEP);
  localparam logic [GAIN_W:0] MAX_W  = (GAIN_W+1)'(GAIN_MAX);

  logic [GAIN_W:0]   gain_w;
  logic [GAIN_W:0]   up_w;
  logic [GAIN_W:0]   dn_w;
  logic [GAIN_W-1:0] gain_nxt;

  // One extra bit on the arithmetic so neither direction can wrap.
  always_comb begin
    gain_w   = {1'b0, gain};
    up_w     = gain_w + STEP_W;
    dn_w     = gain_w - STEP_W;
    gain_nxt = gain;
    if (tick) begin
      if (dir) begin
        gain_nxt = (up_w > MAX_W) ? MAX_W[GAIN_W-1:0] : up_w[GAIN_W-1:0];
      end else begin
        gain_nxt = (gain_w > STEP_W) ? dn_w[GAIN_W-1:0] : '0;
      end
    end
    at_zero = (gain_nxt == '0);
    at_max  = (gain_nxt == MAX_W[GAIN_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain <= MAX_W[GAIN_W-1:0];
    end else begin
      gain <= gain_nxt;
    end
  end

endmodule

// File: rtl/src_switch_ctrl.sv
// src_switch_ctrl: sequences the 5:1 audio source mux select with a
// click-free fade-out -> switch -> settle -> fade-in, and emits the gain
// word applied downstream to the mux output.
// Build option: define SRC_SW_FADE_EN for the faded sequence; without it the
// select updates directly on accept and gain stays at unity.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-cycle audio sample strobe pacing every fade step
//   req_valid    source-change request valid (held until accepted)
//   req_sel      requested source index
//   req_ready    request accepted when req_valid && req_ready
//   mux_sel      select to the source mux
//   gain         gain word for the downstream scaler
//   busy         switch sequence in progress
//   err_pulse    one-cycle pulse for an accepted out-of-range req_sel
module src_switch_ctrl
  import src_sw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              req_valid,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              req_ready,
  output logic [SEL_W-1:0]  mux_sel,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              err_pulse
);

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  logic accept;
  logic bad_sel;

  assign accept  = req_valid && req_ready;
  assign bad_sel = ({1'b0, req_sel} >= NUM_SRC_W);

`ifdef SRC_SW_FADE_EN

  localparam int                CNT_W       = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);

  sw_state_t        state;
  sw_state_t        state_nxt;
  logic [SEL_W-1:0] pending;
  logic [CNT_W-1:0] settle_cnt;
  logic             start;
  logic             ramp_tick;
  logic             ramp_dir;
  logic             at_zero;
  logic             at_max;

  assign start     = accept && !bad_sel && (req_sel != mux_sel);
  // Ticks outside the fades are ignored by the ramp, holding gain steady.
  assign ramp_tick = sample_tick && ((state == FADE_OUT) || (state == FADE_IN));
  assign ramp_dir  = (state == FADE_IN);

  gain_ramp u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (ramp_tick),
    .dir     (ramp_dir),
    .gain    (gain),
    .at_zero (at_zero),
    .at_max  (at_max)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)                                     state_nxt = FADE_OUT;
      FADE_OUT: if (ramp_tick && at_zero)                      state_nxt = SWITCH;
      SWITCH:   if (sample_tick && (settle_cnt == SETTLE_LAST)) state_nxt = FADE_IN;
      FADE_IN:  if (ramp_tick && at_max)                       state_nxt = IDLE;
      default:                                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      settle_cnt <= '0;
      mux_sel    <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      err_pulse  <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      req_ready <= (state_nxt == IDLE);
      err_pulse <= accept && bad_sel;
      if (start) begin
        pending <= req_sel;
      end
      // Held at zero in every other state, so SWITCH always starts counting from 0.
      if (state != SWITCH) begin
        settle_cnt <= '0;
      end else if (sample_tick) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
      if ((state == SWITCH) && (gain == '0)) begin
        mux_sel <= pending;
      end
    end
  end

`else

  logic unused_tick;
  assign unused_tick = sample_tick;

  assign req_ready = 1'b1;
  assign gain      = '1;
  assign busy      = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept && bad_sel;
      if (accept && !bad_sel) begin
        mux_sel <= req_sel;
      end
    end
  end

`endif

endmodule

// File: tb/tb_src_switch_ctrl.sv
// Self-checking bench for src_switch_ctrl; covers both the faded build
// (SRC_SW_FADE_EN defined) and the direct-select build.
module tb_src_switch_ctrl;

  localparam int NSRC     = 5;
  localparam int GMAX     = 255;
  localparam int STEP     = 8;
  localparam int DOWN_N   = 32;
  localparam int SETTLE_N = 4;
  localparam int UP_N     = 32;
  localparam int TICK_DIV = 4;
  localparam int SEQ_LEN  = DOWN_N + SETTLE_N + UP_N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       req_valid;
  logic [2:0] req_sel;
  logic       req_ready;
  logic [2:0] mux_sel;
  logic [7:0] gain;
  logic       busy;
  logic       err_pulse;

  always #5 clk = ~clk;

  src_switch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_ready   (req_ready),
    .mux_sel     (mux_sel),
    .gain        (gain),
    .busy        (busy),
    .err_pulse   (err_pulse)
  );

  typedef struct {
    bit on_tick;
    int gain;
    int sel;
    int busy;
    int ready;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model_sel = 0;
  int   tick_div = 0;
  bit   tick_on = 1'b0;
  bit   prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Expected per-tick outputs of one full faded switch.
  task automatic push_switch(input int old_sel, input int new_sel);
    int g;
    for (int k = 1; k <= DOWN_N; k++) begin
      g = GMAX - STEP * k;
      if (g < 0) g = 0;
      sb.push_back('{1'b1, g, old_sel, 1, 0});
    end
    for (int k = 1; k <= SETTLE_N; k++) sb.push_back('{1'b1, 0, new_sel, 1, 0});
    for (int k = 1; k <= UP_N; k++) begin
      g = STEP * k;
      if (g > GMAX) g = GMAX;
      sb.push_back('{1'b1, g, new_sel, (k < UP_N) ? 1 : 0, (k < UP_N) ? 0 : 1});
    end
  endtask

  task automatic step();
    logic tk;
    logic acc;
    logic exp_err;
    logic [2:0] prev_mux;
    exp_t e;
    int s;
    tk = tick_on && (tick_div == 0);
    tick_div = (tick_div + 1) % TICK_DIV;
    sample_tick = tk;
    acc = req_valid && req_ready;
    exp_err = 1'b0;
    if (prev_done && req_valid) chk("first_idle_accept", 32'(acc), 1);
    prev_done = 1'b0;
    if (acc) begin
      s = int'(req_sel);
      if (s >= NSRC) begin
        exp_err = 1'b1;
      end else if (s != model_sel) begin
`ifdef SRC_SW_FADE_EN
        push_switch(model_sel, s);
`else
        sb.push_back('{1'b0, GMAX, s, 0, 1});
`endif
        model_sel = s;
      end
    end
    prev_mux = mux_sel;
    @(posedge clk);
    #1;
    if (acc) req_valid = 1'b0;
    chk("err_pulse", 32'(err_pulse), 32'(exp_err));
    if (sb.size() > 0 && (sb[0].on_tick ? (tk && !acc) : 1'b1)) begin
      e = sb.pop_front();
      chk("seq_gain", 32'(gain), e.gain);
      chk("seq_mux_sel", 32'(mux_sel), e.sel);
      chk("seq_busy", 32'(busy), e.busy);
      chk("seq_ready", 32'(req_ready), e.ready);
      if (e.on_tick && e.ready == 1) prev_done = 1'b1;
    end else if (sb.size() == 0) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gain", 32'(gain), GMAX);
      chk("idle_ready", 32'(req_ready), 1);
      chk("idle_mux_sel", 32'(mux_sel), model_sel);
    end
`ifdef SRC_SW_FADE_EN
    if (mux_sel !== prev_mux) chk("mux_change_at_zero", 32'(gain), 0);
`endif
  endtask

  task automatic run_seq(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      chk("seq_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input int s);
    int n = 0;
    req_sel = 3'(s);
    req_valid = 1'b1;
    while (req_valid && n < 600) begin
      step();
      n++;
    end
    if (req_valid) begin
      chk("accept_timeout", 32'(req_valid), 0);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    sample_tick = 1'b0;
    req_valid = 1'b0;
    req_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_mux_sel", 32'(mux_sel), 0);
    chk("rst_gain", 32'(gain), GMAX);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick_on = 1'b1;
    repeat (5) step();

    // Full switch 0 -> 3.
    issue(3);
    run_seq(SEQ_LEN * TICK_DIV + 40);
    repeat (3) step();

    // Move to 2, then request the current source: a no-op.
    issue(2);
    run_seq(SEQ_LEN * TICK_DIV + 40);
    issue(2);
    repeat (8) step();

    // Out-of-range request.
    issue(6);
    repeat (4) step();

    // Request held during the fade-in of a prior switch.
    issue(1);
    n = 0;
    while (sb.size() > UP_N - 12 && n < 600) begin
      step();
      n++;
    end
    req_sel = 3'd4;
    req_valid = 1'b1;
    run_seq(SEQ_LEN * TICK_DIV + 40);
    step();
    if (req_valid) begin
      chk("held_req_accepted", 32'(req_valid), 0);
      req_valid = 1'b0;
    end
    run_seq(SEQ_LEN * TICK_DIV + 40);
    repeat (3) step();

    // Asynchronous reset part way through a fade-out.
    issue(2);
    n = 0;
    while (sb.size() > SEQ_LEN - 17 && n < 600) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mux_sel", 32'(mux_sel), 0);
    chk("midrst_gain", 32'(gain), GMAX);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_err", 32'(err_pulse), 0);
    sb.delete();
    model_sel = 0;
    req_valid = 1'b0;
    prev_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) step();

    // Direct-select style checks (also valid for the faded build).
    issue(4);
    run_seq(SEQ_LEN * TICK_DIV + 40);
    issue(5);
    repeat (3) step();
    issue(4);
    repeat (3) step();
    issue(7);
    repeat (3) step();
    issue(0);
    run_seq(SEQ_LEN * TICK_DIV + 40);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
